// File: rtl/bcd_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding and the BCD segment table ({g,f,e,d,c,b,a}, active-high).
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry 0 sits in the least significant slice; codes 10..15 are blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bcd_scan_ctrl_if.sv
// Host write port of the scan controller. A write is a single-cycle strobe:
// wr_en high at a rising edge transfers wr_data to wr_addr; there is no ready, every write is accepted.
interface bcd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/bcd_scan_ctrl_seg_dec.sv
// Combinational BCD to seven-segment decoder, one instance shared by all positions.
module bcd_seg_dec
  import bcd_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a blanking gap between digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero positions (position 0 never blanked).
module bcd_scan_ctrl
  import bcd_scan_pkg::*;
#(
  parameter int  NUM_DIGITS = 4,
  parameter int  SCAN_DIV   = 4,
  parameter int  GAP_CYCLES = 1,
  localparam int AW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_asyn,
  input  logic                  enable,
  bcd_scan_ctrl_if.slave        wr,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [AW-1:0]         digit_idx,
  output logic                  frame_done,
  output scan_state_e           state_dbg
);

  localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]         SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]         GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW-1:0]         IDX_LAST  = AW'(NUM_DIGITS - 1);
  localparam logic [AW:0]           ND        = (AW + 1)'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};

  scan_state_e                 state_q, state_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               pre_q, pre_d;
  logic [NUM_DIGITS-1:0][3:0]  digit_q, digit_d;
  logic [6:0]                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic                        fd_q, fd_d;
  logic                        advance;
  logic                        blank_lz;
  logic [3:0]                  dec_in;
  logic [6:0]                  dec_seg;

  always_ff @(posedge clk or posedge rst_asyn) begin
    if (rst_asyn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      digit_q <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    digit_d = digit_q;
    if (wr.wr_en && ({1'b0, wr.wr_addr} < ND)) begin
      digit_d[wr.wr_addr] = wr.wr_data;
    end
  end

  // The prescaler times both the lit slot and the gap; it is cleared on every state change.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    fd_d    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        pre_d = '0;
        if (enable) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (pre_q == SHOW_LAST) begin
          pre_d = '0;
          if (GAP_CYCLES > 0) state_d = ST_GAP;
          else                advance = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (pre_q == GAP_LAST) begin
          pre_d   = '0;
          advance = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Enable is only honoured at slot boundaries so a slot is never truncated.
    if (advance) begin
      fd_d  = (idx_q == IDX_LAST);
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (enable) begin
        state_d = ST_SHOW;
      end else begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    end
  end

  // Outputs are computed from next-state so they are registered on the edge entering a state.
  assign dec_in = digit_q[idx_d];

  bcd_seg_dec u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_lz = (dec_in == 4'd0) && (idx_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i > int'(idx_d)) && (digit_q[i] != 4'd0)) blank_lz = 1'b0;
    end
`else
    blank_lz = 1'b0;
`endif
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (state_d == ST_SHOW) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = blank_lz ? SEG_BLANK : dec_seg;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl (4 digits, 4-cycle slots, 1-cycle gap).
// Honours LEADING_ZERO_BLANK_EN when the same macro is given to the build.
module tb_bcd_scan_ctrl;
  import bcd_scan_pkg::*;

  localparam int W = 14;  // {frame_done, digit_idx[1:0], seg[6:0], an[3:0]}

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst_asyn;
  logic        enable;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;
  scan_state_e state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;

  bcd_scan_ctrl_if #(.NUM_DIGITS(4)) wr_if ();

  bcd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .GAP_CYCLES(1)) dut (
    .clk        (clk),
    .rst_asyn   (rst_asyn),
    .enable     (enable),
    .wr         (wr_if),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    string        n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      got = {frame_done, digit_idx, seg, an};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s got fd=%b idx=%0d seg=%h an=%b exp fd=%b idx=%0d seg=%h an=%b",
                 n, got[13], got[12:11], got[10:4], got[3:0],
                 e[13], e[12:11], e[10:4], e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input string nm, input logic fd, input logic [1:0] idx,
                      input logic [6:0] s, input logic [3:0] a);
    exp_q.push_back({fd, idx, s, a});
    name_q.push_back(nm);
  endtask

  // Advance one clock edge and queue the outputs expected for the following cycle.
  task automatic tick(input string nm, input logic fd, input logic [1:0] idx,
                      input logic [6:0] s, input logic [3:0] a);
    @(posedge clk);
    #1;
    push(nm, fd, idx, s, a);
  endtask

  task automatic wr_idle(input logic [1:0] addr, input logic [3:0] data);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = addr;
    wr_if.wr_data = data;
    tick("idle_wr", 1'b0, 2'd0, 7'h00, 4'b1111);
    wr_if.wr_en   = 1'b0;
  endtask

  // One slot: 4 lit cycles then 1 gap cycle. ev_kind 1 = write at lit cycle ev_at
  // (s1 shown from the next cycle on), ev_kind 2 = drop enable at lit cycle ev_at.
  task automatic slot(input string nm, input int idx, input logic [6:0] s0, input logic fd,
                      input int ev_at, input int ev_kind, input logic [1:0] wa,
                      input logic [3:0] wd, input logic [6:0] s1);
    logic [3:0] an_l;
    logic [6:0] s;
    an_l = ~(4'b0001 << idx);
    for (int k = 0; k < 4; k++) begin
      if (k == ev_at) begin
        if (ev_kind == 1) begin
          wr_if.wr_en   = 1'b1;
          wr_if.wr_addr = wa;
          wr_if.wr_data = wd;
        end else if (ev_kind == 2) begin
          enable = 1'b0;
        end
      end
      s = (ev_kind == 1 && k > ev_at) ? s1 : s0;
      tick(nm, (k == 0) ? fd : 1'b0, idx[1:0], s, an_l);
      wr_if.wr_en = 1'b0;
    end
    tick({nm, "_gap"}, 1'b0, idx[1:0], 7'h00, 4'b1111);
  endtask

  task automatic slot_p(input string nm, input int idx, input logic [6:0] s, input logic fd);
    slot(nm, idx, s, fd, -1, 0, 2'd0, 4'd0, s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_asyn      = 1'b1;
    enable        = 1'b0;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;

    // reset state
    tick("reset_0", 1'b0, 2'd0, 7'h00, 4'b1111);
    tick("reset_1", 1'b0, 2'd0, 7'h00, 4'b1111);
    rst_asyn = 1'b0;
    tick("idle_after_reset", 1'b0, 2'd0, 7'h00, 4'b1111);

    // single digit 5 at position 0, remaining positions still 0
    wr_idle(2'd0, 4'd5);
    enable = 1'b1;
    slot_p("s2_slot0", 0, 7'h6D, 1'b0);
    slot_p("s2_slot1", 1, LZ, 1'b0);
    slot_p("s2_slot2", 2, LZ, 1'b0);
    slot_p("s2_slot3", 3, LZ, 1'b0);
    enable = 1'b0;
    tick("s2_wrap_idle", 1'b1, 2'd0, 7'h00, 4'b1111);
    tick("s2_idle", 1'b0, 2'd0, 7'h00, 4'b1111);

    // digits 4,3,2,1 with enable held over two frames
    wr_idle(2'd3, 4'd4);
    wr_idle(2'd2, 4'd3);
    wr_idle(2'd1, 4'd2);
    wr_idle(2'd0, 4'd1);
    enable = 1'b1;
    slot_p("s3_f1_slot0", 0, 7'h06, 1'b0);
    slot_p("s3_f1_slot1", 1, 7'h5B, 1'b0);
    slot_p("s3_f1_slot2", 2, 7'h4F, 1'b0);
    slot_p("s3_f1_slot3", 3, 7'h66, 1'b0);
    slot_p("s3_f2_slot0", 0, 7'h06, 1'b1);
    slot_p("s3_f2_slot1", 1, 7'h5B, 1'b0);
    slot_p("s3_f2_slot2", 2, 7'h4F, 1'b0);
    slot_p("s3_f2_slot3", 3, 7'h66, 1'b0);

    // invalid BCD on position 2, then 9 written while position 2 is lit
    slot("s4_slot0", 0, 7'h06, 1'b1, 1, 1, 2'd2, 4'hC, 7'h06);
    slot_p("s4_slot1", 1, 7'h5B, 1'b0);
    slot("s4_slot2", 2, 7'h00, 1'b0, 1, 1, 2'd2, 4'd9, 7'h6F);
    slot_p("s4_slot3", 3, 7'h66, 1'b0);

    // enable dropped mid-slot: slot and gap complete, then idle; restart at 0
    slot_p("s5_slot0", 0, 7'h06, 1'b1);
    slot("s5_slot1", 1, 7'h5B, 1'b0, 2, 2, 2'd0, 4'd0, 7'h5B);
    tick("s5_idle_0", 1'b0, 2'd0, 7'h00, 4'b1111);
    tick("s5_idle_1", 1'b0, 2'd0, 7'h00, 4'b1111);
    enable = 1'b1;
    slot_p("s5_re_slot0", 0, 7'h06, 1'b0);
    slot_p("s5_re_slot1", 1, 7'h5B, 1'b0);
    slot_p("s5_re_slot2", 2, 7'h6F, 1'b0);
    slot_p("s5_re_slot3", 3, 7'h66, 1'b0);
    enable = 1'b0;
    tick("s5_wrap_idle", 1'b1, 2'd0, 7'h00, 4'b1111);

    // leading zeros: digits 0,0,7,0 on positions 3..0
    wr_idle(2'd3, 4'd0);
    wr_idle(2'd2, 4'd0);
    wr_idle(2'd1, 4'd7);
    wr_idle(2'd0, 4'd0);
    enable = 1'b1;
    slot_p("s6_slot0", 0, 7'h3F, 1'b0);
    slot_p("s6_slot1", 1, 7'h07, 1'b0);
    slot_p("s6_slot2", 2, LZ, 1'b0);
    slot_p("s6_slot3", 3, LZ, 1'b0);
    slot_p("s6_f2_slot0", 0, 7'h3F, 1'b1);

    // asynchronous reset between edges while slot 1 is lit
    tick("s1_show_0", 1'b0, 2'd1, 7'h07, 4'b1101);
    tick("s1_show_1", 1'b0, 2'd1, 7'h07, 4'b1101);
    @(posedge clk);
    #1;
    rst_asyn = 1'b1;
    #1;
    push("s1_async_rst", 1'b0, 2'd0, 7'h00, 4'b1111);
    tick("s1_rst_hold", 1'b0, 2'd0, 7'h00, 4'b1111);
    rst_asyn = 1'b0;
    slot_p("s1_post_slot0", 0, 7'h3F, 1'b0);
    slot_p("s1_post_slot1", 1, LZ, 1'b0);
    slot_p("s1_post_slot2", 2, LZ, 1'b0);
    slot_p("s1_post_slot3", 3, LZ, 1'b0);
    enable = 1'b0;
    tick("s1_wrap_idle", 1'b1, 2'd0, 7'h00, 4'b1111);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
